link_arbiter: RTL

Round-robin arbiter that shares one req/ack byte link and its downstream slave among N burst masters. Each master runs the team's 4-phase req/ack protocol for fixed-length bursts. The arbiter grants the link to one master for a whole burst and passes that master's req and data through to the slave, routing ack back. It sits between the master FSMs and the single slave. It also releases the link if the owner stalls between bytes.

---
 rtl/link_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/link_arbiter.sv
// rtl/link_arbiter.sv - round-robin burst arbiter sharing one req/ack byte link among N masters
module link_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS*DATA_W-1:0]   m_data,
   output logic [N_MASTERS-1:0]          m_ack,
   output logic                          s_req,
   output logic [DATA_W-1:0]             s_data,
   input  logic                          s_ack,
   output logic [N_MASTERS-1:0]          grant,
   output logic                          busy,
   output logic                          burst_done,
   output logic                          timeout_err
);
   localparam int IDX_W = $clog2(N_MASTERS);
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] owner, last_owner, winner, cand;
   logic             found;
   logic [CNT_W-1:0] byte_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             ack_q;
   logic             byte_done, last_byte, link_idle, to_hit, do_grant;

   // grant is zero outside BUSY, so gating by grant alone covers the idle/release cases
   assign s_req     = |(m_req & grant);
   assign m_ack     = s_ack ? grant : '0;
   assign byte_done = (state == BUSY) && ack_q && !s_ack;
   assign last_byte = (byte_cnt == CNT_W'(BURST_LEN - 1));
   assign link_idle = !s_req && !s_ack;
   assign to_hit    = (state == BUSY) && link_idle && (to_cnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      s_data = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (grant[i]) s_data = m_data[i*DATA_W +: DATA_W];
      end
   end

   // first requester strictly after last_owner, wrapping
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int i = 1; i <= N_MASTERS; i++) begin
         cand = IDX_W'((int'(last_owner) + i) % N_MASTERS);
         if (!found && m_req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_n  = state;
      do_grant = 1'b0;
      case (state)
         IDLE: begin
            if (!s_ack && found) begin
               do_grant = 1'b1;
               state_n  = BUSY;
            end
         end
         BUSY: begin
            if ((byte_done && last_byte) || to_hit) state_n = RELEASE;
         end
         RELEASE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant       <= '0;
         busy        <= 1'b0;
         owner       <= '0;
         last_owner  <= IDX_W'(N_MASTERS - 1);
         byte_cnt    <= '0;
         to_cnt      <= '0;
         ack_q       <= 1'b0;
         burst_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         burst_done  <= 1'b0;
         timeout_err <= 1'b0;
         ack_q       <= s_ack;
         if (do_grant) begin
            grant    <= N_MASTERS'(1) << winner;
            busy     <= 1'b1;
            owner    <= winner;
            byte_cnt <= '0;
            to_cnt   <= '0;
         end else if (state == BUSY) begin
            if ((byte_done && last_byte) || to_hit) begin
               burst_done  <= byte_done && last_byte;
               timeout_err <= !(byte_done && last_byte);
               grant       <= '0;
               busy        <= 1'b0;
               last_owner  <= owner;
               to_cnt      <= '0;
            end else begin
               if (byte_done) byte_cnt <= byte_cnt + CNT_W'(1);
               to_cnt <= link_idle ? to_cnt + TO_W'(1) : '0;
            end
         end
      end
   end
endmodule
